// File: rtl/fbuf_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : fbuf_timing_gen
// Brief    : Raster timing generator and framebuffer read-address sequencer.
//            Optional fetch window is enabled by defining FBUF_WINDOW_EN.
// Revision : 1.0
// ============================================================================
module fbuf_timing_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter bit HS_POL          = 1'b1,
    parameter bit VS_POL          = 1'b1,
    parameter int SCALE_X_LOG2    = 0,
    parameter int SCALE_Y_LOG2    = 0,
    parameter int FBUF_ADDR_WIDTH = 19,
    parameter int CONTROL_DELAY   = 1
`ifdef FBUF_WINDOW_EN
    ,
    parameter int WIN_X0          = 0,
    parameter int WIN_Y0          = 0,
    parameter int WIN_W           = H_ACTIVE,
    parameter int WIN_H           = V_ACTIVE
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       resync,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       vde,
    output logic                       eof,
    output logic                       sof,
    output logic                       in_window,
    output logic                       fbuf_rd_en,
    output logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_address,
    output logic [12:0]                pixel_x,
    output logic [12:0]                pixel_y
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL + 1);
    localparam int c_VW      = $clog2(c_V_TOTAL + 1);

`ifdef FBUF_WINDOW_EN
    localparam int c_WIN_X0 = WIN_X0;
    localparam int c_WIN_Y0 = WIN_Y0;
    localparam int c_WIN_W  = WIN_W;
    localparam int c_WIN_H  = WIN_H;
`else
    localparam int c_WIN_X0 = 0;
    localparam int c_WIN_Y0 = 0;
    localparam int c_WIN_W  = H_ACTIVE;
    localparam int c_WIN_H  = V_ACTIVE;
`endif

    localparam int c_LINE_WORDS_I = c_WIN_W >> SCALE_X_LOG2;
    localparam int c_FB_LINES     = c_WIN_H >> SCALE_Y_LOG2;

    localparam logic [c_HW-1:0] c_H_ONE    = c_HW'(1);
    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_START = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_HW-1:0] c_WX0      = c_HW'(c_WIN_X0);
    localparam logic [c_HW-1:0] c_WW       = c_HW'(c_WIN_W);
    localparam logic [c_HW-1:0] c_WX_LAST  = c_HW'(c_WIN_X0 + c_WIN_W - 1);

    localparam logic [c_VW-1:0] c_V_ONE    = c_VW'(1);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_START = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_VW-1:0] c_WY0      = c_VW'(c_WIN_Y0);
    localparam logic [c_VW-1:0] c_WH       = c_VW'(c_WIN_H);

    localparam logic [FBUF_ADDR_WIDTH-1:0] c_ADDR_ONE   = FBUF_ADDR_WIDTH'(1);
    localparam logic [FBUF_ADDR_WIDTH-1:0] c_LINE_WORDS = FBUF_ADDR_WIDTH'(c_LINE_WORDS_I);
    localparam logic [1:0]                 c_SX_MAX     = 2'((1 << SCALE_X_LOG2) - 1);
    localparam logic [1:0]                 c_SY_MAX     = 2'((1 << SCALE_Y_LOG2) - 1);
    localparam logic [1:0]                 c_PH_ONE     = 2'd1;

    typedef struct packed {
        logic        vde;
        logic        hsync;
        logic        vsync;
        logic        eof;
        logic        sof;
        logic        in_window;
        logic [12:0] pixel_x;
        logic [12:0] pixel_y;
    } ctrl_t;

    localparam ctrl_t c_CTRL_IDLE = '{
        vde: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL, eof: 1'b0, sof: 1'b0,
        in_window: 1'b0, pixel_x: 13'd0, pixel_y: 13'd0
    };

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (SCALE_X_LOG2 < 0 || SCALE_X_LOG2 > 2 || SCALE_Y_LOG2 < 0 || SCALE_Y_LOG2 > 2) begin : g_err_scale_range
            $error("fbuf_timing_gen: SCALE_X_LOG2/SCALE_Y_LOG2 must be 0..2");
        end
        if ((H_ACTIVE % (1 << SCALE_X_LOG2)) != 0 || (V_ACTIVE % (1 << SCALE_Y_LOG2)) != 0) begin : g_err_scale_div
            $error("fbuf_timing_gen: active area not a multiple of the scale factor");
        end
        if (longint'(c_LINE_WORDS_I) * longint'(c_FB_LINES) > (longint'(1) << FBUF_ADDR_WIDTH)) begin : g_err_addr_width
            $error("fbuf_timing_gen: framebuffer does not fit FBUF_ADDR_WIDTH");
        end
        if (CONTROL_DELAY < 1) begin : g_err_ctrl_delay
            $error("fbuf_timing_gen: CONTROL_DELAY must be at least 1");
        end
        if (c_WIN_W < 1 || c_WIN_H < 1 || c_WIN_X0 < 0 || c_WIN_Y0 < 0 ||
            c_WIN_X0 + c_WIN_W > H_ACTIVE || c_WIN_Y0 + c_WIN_H > V_ACTIVE) begin : g_err_win_bounds
            $error("fbuf_timing_gen: fetch window lies outside the active area");
        end
        if ((c_WIN_X0 % (1 << SCALE_X_LOG2)) != 0 || (c_WIN_W % (1 << SCALE_X_LOG2)) != 0 ||
            (c_WIN_Y0 % (1 << SCALE_Y_LOG2)) != 0 || (c_WIN_H % (1 << SCALE_Y_LOG2)) != 0) begin : g_err_win_scale
            $error("fbuf_timing_gen: fetch window not aligned to the scale factor");
        end
    endgenerate

    logic [c_HW-1:0]            r_h;
    logic [c_VW-1:0]            r_v;
    logic [FBUF_ADDR_WIDTH-1:0] r_x_addr;
    logic [FBUF_ADDR_WIDTH-1:0] r_line_base;
    logic [1:0]                 r_x_phase;
    logic [1:0]                 r_y_phase;
    logic [FBUF_ADDR_WIDTH-1:0] r_addr;
    logic                       r_rd_en;
    ctrl_t                      r_ctrl [0:CONTROL_DELAY];

    logic                       w_h_last;
    logic                       w_v_last;
    logic                       w_active;
    logic [c_HW-1:0]            w_win_dx;
    logic [c_VW-1:0]            w_win_dy;
    logic                       w_in_win;
    logic                       w_win_row_end;
    ctrl_t                      w_ctrl;

    always_comb begin
        w_h_last      = (r_h == c_H_LAST);
        w_v_last      = (r_v == c_V_LAST);
        w_active      = (r_h < c_H_ACT) && (r_v < c_V_ACT);
        // Offsets wrap to large values left/above the window, so one compare per axis suffices
        w_win_dx      = r_h - c_WX0;
        w_win_dy      = r_v - c_WY0;
        w_in_win      = (w_win_dx < c_WW) && (w_win_dy < c_WH);
        w_win_row_end = w_in_win && (r_h == c_WX_LAST);

        w_ctrl           = c_CTRL_IDLE;
        w_ctrl.vde       = w_active;
        w_ctrl.hsync     = ((r_h >= c_HS_START) && (r_h < c_HS_END)) ? HS_POL : ~HS_POL;
        w_ctrl.vsync     = ((r_v >= c_VS_START) && (r_v < c_VS_END)) ? VS_POL : ~VS_POL;
        w_ctrl.eof       = (r_v >= c_V_ACT);
        w_ctrl.sof       = w_active && (r_h == '0) && (r_v == '0);
        w_ctrl.in_window = w_in_win;
        w_ctrl.pixel_x   = w_active ? 13'(r_h) : 13'd0;
        w_ctrl.pixel_y   = w_active ? 13'(r_v) : 13'd0;
    end

    // Raster counters and address accumulators; reset, resync and idle all restart at (0,0)
    always_ff @(posedge clk) begin
        if (!rst_n || resync || !enable) begin
            r_h         <= '0;
            r_v         <= '0;
            r_x_addr    <= '0;
            r_line_base <= '0;
            r_x_phase   <= '0;
            r_y_phase   <= '0;
        end else begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + c_V_ONE;
            end else begin
                r_h <= r_h + c_H_ONE;
            end

            if (w_h_last && w_v_last) begin
                r_x_addr    <= '0;
                r_line_base <= '0;
                r_x_phase   <= '0;
                r_y_phase   <= '0;
            end else if (w_win_row_end) begin
                r_x_addr  <= '0;
                r_x_phase <= '0;
                if (r_y_phase == c_SY_MAX) begin
                    r_line_base <= r_line_base + c_LINE_WORDS;
                    r_y_phase   <= '0;
                end else begin
                    r_y_phase <= r_y_phase + c_PH_ONE;
                end
            end else if (w_in_win) begin
                if (r_x_phase == c_SX_MAX) begin
                    r_x_addr  <= r_x_addr + c_ADDR_ONE;
                    r_x_phase <= '0;
                end else begin
                    r_x_phase <= r_x_phase + c_PH_ONE;
                end
            end
        end
    end

    // Stage 0 (address) followed by CONTROL_DELAY control-only stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_rd_en <= 1'b0;
            for (int i = 0; i <= CONTROL_DELAY; i++) begin
                r_ctrl[i] <= c_CTRL_IDLE;
            end
        end else begin
            if (enable) begin
                r_rd_en   <= w_in_win;
                r_addr    <= w_in_win ? (r_line_base + r_x_addr) : '0;
                r_ctrl[0] <= w_ctrl;
            end else begin
                r_rd_en   <= 1'b0;
                r_addr    <= '0;
                r_ctrl[0] <= c_CTRL_IDLE;
            end
            for (int i = 1; i <= CONTROL_DELAY; i++) begin
                r_ctrl[i] <= r_ctrl[i-1];
            end
        end
    end

    assign fbuf_rd_en         = r_rd_en;
    assign pixel_fbuf_address = r_addr;
    assign vde                = r_ctrl[CONTROL_DELAY].vde;
    assign hsync              = r_ctrl[CONTROL_DELAY].hsync;
    assign vsync              = r_ctrl[CONTROL_DELAY].vsync;
    assign eof                = r_ctrl[CONTROL_DELAY].eof;
    assign sof                = r_ctrl[CONTROL_DELAY].sof;
    assign in_window          = r_ctrl[CONTROL_DELAY].in_window;
    assign pixel_x            = r_ctrl[CONTROL_DELAY].pixel_x;
    assign pixel_y            = r_ctrl[CONTROL_DELAY].pixel_y;

endmodule
`default_nettype wire
